idivn: RTL and testbench
========================

IDIVN -- requirements
Module: idivn

Interface
REQ-001 SHALL have parameter WIDTH, default 8: divisor, quotient and remainder width; dividend is 2*WIDTH bits; legal 4..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high; one clock, no other reset.
REQ-004 SHALL have port go  input  1  start request, sampled on clk.
REQ-005 SHALL have port sgn  input  1  1 = signed two's-complement operation, 0 = unsigned; sampled with go.
REQ-006 SHALL have port dividend  input  2*WIDTH  numerator, sampled with go.
REQ-007 SHALL have port divisor  input  WIDTH  denominator, sampled with go.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port quot  output  WIDTH  quotient, held until next done.
REQ-011 SHALL have port rem  output  WIDTH  remainder, held until next done.
REQ-012 SHALL have port overflow  output  1  quotient unrepresentable, held until next done.
REQ-013 SHALL have port div0  output  1  divisor was zero, held until next done.

Function
REQ-014 SHALL implement FSM IDLE -> ITER -> FIX -> IDLE; restoring shift-subtract, one quotient bit per cycle.
REQ-015 SHALL accept go only in IDLE; go while busy is ignored, with no effect on the running operation.
REQ-016 SHALL, on go accepted at edge k: latch operands, assert busy from k+1; done and results at edge k+WIDTH+2; busy low in the same cycle done is high.
REQ-017 SHALL allow go in the done cycle; it is accepted as back-to-back operation.
REQ-018 SHALL, unsigned: overflow=1 when dividend[2W-1:W] >= divisor; quot = floor(dividend/divisor), rem = dividend mod divisor otherwise.
REQ-019 SHALL, signed: divide magnitudes; truncate toward zero; rem takes dividend's sign; quot negated when operand signs differ (sign correction in FIX).
REQ-020 SHALL, signed: overflow=1 when magnitude quotient exceeds 2^(W-1)-1 (positive result) or 2^(W-1) (negative result), or high-half magnitude check fails.
REQ-021 SHALL, divisor==0: div0=1 and overflow=1, same latency as a normal operation.
REQ-022 SHALL, on overflow or div0: quot = all ones, rem = 0.
REQ-023 SHALL keep done low except for the single completion cycle.

Reset
REQ-024 SHALL, on rst high at a clk edge: FSM to IDLE; busy=0, done=0, quot=0, rem=0, overflow=0, div0=0.
REQ-025 SHALL abandon an in-flight operation on reset, with no done pulse; rst has priority over go.

Configuration
REQ-026 SHALL gate signed support with macro IDIVN_SIGNED_EN: defined -> REQ-019/020 behaviour; undefined -> sgn ignored, all operations unsigned, and no sign-correction logic (FIX still occupies one cycle, so latency is unchanged).

Structure
REQ-027 SHALL place the FSM state enum and the result constants (overflow quot/rem values) in shared package idivn_pkg.
REQ-028 SHALL place one iteration step (shift, trial subtract, quotient bit) in sub-module idivn_step, instantiated once.

Verification (WIDTH=8)
REQ-029 SHALL test unsigned 46845/200: done 10 cycles after go; quot=234, rem=45, overflow=0.
REQ-030 SHALL test unsigned 51200/200: overflow=1, quot=0xFF, rem=0.
REQ-031 SHALL test 100/0: div0=1, overflow=1, done after 10 cycles.
REQ-032 SHALL test signed -100/7 (0xFF9C/0x07): quot=0xF2 (-14), rem=0xFE (-2); signed -32768/-1: overflow=1.
REQ-033 SHALL test go pulsed while busy: ignored, first result unchanged; go in done cycle starts the next operation.
REQ-034 SHALL test rst asserted 4 cycles into an operation: all outputs 0 next cycle, no done pulse, and a new go then completes normally.

Source files
------------

// File: rtl/idivn_pkg.sv
// Shared types and result constants for the idivn restoring divider.
package idivn_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Fill bits for quot/rem when the quotient is unrepresentable or divisor is zero.
  localparam logic OVF_QUOT_BIT = 1'b1;
  localparam logic OVF_REM_BIT  = 1'b0;

endpackage

// File: rtl/idivn_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, emit a quotient bit.
module idivn_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_part,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_part,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;

  assign w_shift = {i_part, i_bit};
  // Low bits suffice: whenever the subtract is taken the difference is below i_div.
  assign w_sub   = w_shift[WIDTH-1:0] - i_div;
  assign o_qbit  = (w_shift >= {1'b0, i_div});
  assign o_part  = o_qbit ? w_sub : w_shift[WIDTH-1:0];

endmodule

// File: rtl/idivn.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle.
// Signed operation is compiled in only when IDIVN_SIGNED_EN is defined.
module idivn
  import idivn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 sgn,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem,
  output logic                 overflow,
  output logic                 div0,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_div, r_lo, r_part, r_q, r_quot, r_rem;
  logic             r_ovf_hi, r_div0, r_ovf, r_dz, r_done;

  logic [2*WIDTH-1:0] w_mag_dvd;
  logic [WIDTH-1:0]   w_mag_dvs;
  logic [WIDTH-1:0]   w_step_part, w_fix_quot, w_fix_rem;
  logic               w_step_q, w_fix_ovf;

`ifdef IDIVN_SIGNED_EN
  logic r_sgn, r_neg_q, r_neg_r;
  logic w_dvd_neg, w_dvs_neg, w_sgn_ovf;

  assign w_dvd_neg = sgn & dividend[2*WIDTH-1];
  assign w_dvs_neg = sgn & divisor[WIDTH-1];
  assign w_mag_dvd = w_dvd_neg ? -dividend : dividend;
  assign w_mag_dvs = w_dvs_neg ? -divisor : divisor;

  // A negative result may reach -2^(W-1); a positive one stops at 2^(W-1)-1.
  assign w_sgn_ovf  = r_sgn & r_q[WIDTH-1] & (~r_neg_q | (|r_q[WIDTH-2:0]));
  assign w_fix_ovf  = r_ovf_hi | r_div0 | w_sgn_ovf;
  assign w_fix_quot = r_neg_q ? -r_q : r_q;
  assign w_fix_rem  = r_neg_r ? -r_part : r_part;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && go) begin
      r_sgn   <= sgn;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_mag_dvd    = dividend;
  assign w_mag_dvs    = divisor;
  assign w_fix_ovf    = r_ovf_hi | r_div0;
  assign w_fix_quot   = r_q;
  assign w_fix_rem    = r_part;
`endif

  idivn_step #(.WIDTH(WIDTH)) u_step (
    .i_part (r_part),
    .i_bit  (r_lo[WIDTH-1]),
    .i_div  (r_div),
    .o_part (w_step_part),
    .o_qbit (w_step_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (go) w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == CW'(WIDTH)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ITER cycle 0 performs the high-half range check; cycles 1..WIDTH each retire one quotient bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_lo     <= '0;
      r_part   <= '0;
      r_q      <= '0;
      r_ovf_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_part <= w_mag_dvd[2*WIDTH-1:WIDTH];
            r_lo   <= w_mag_dvd[WIDTH-1:0];
            r_div  <= w_mag_dvs;
            r_div0 <= (divisor == '0);
            r_cnt  <= '0;
            r_q    <= '0;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == '0) begin
            r_ovf_hi <= (r_part >= r_div);
          end else begin
            r_part <= w_step_part;
            r_lo   <= {r_lo[WIDTH-2:0], 1'b0};
            r_q    <= {r_q[WIDTH-2:0], w_step_q};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          r_ovf  <= w_fix_ovf;
          r_dz   <= r_div0;
          r_quot <= w_fix_ovf ? {WIDTH{OVF_QUOT_BIT}} : w_fix_quot;
          r_rem  <= w_fix_ovf ? {WIDTH{OVF_REM_BIT}}  : w_fix_rem;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign overflow    = r_ovf;
  assign div0        = r_dz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_idivn.sv
// Directed bench for idivn (WIDTH=8): stimulus pushes expected results, a negedge monitor checks them.
module tb_idivn;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, go, sgn;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy, done, overflow, div0;
  logic [W-1:0]   quot, rem;
  logic [1:0]     dbg_state;

  idivn #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .sgn         (sgn),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quot        (quot),
    .rem         (rem),
    .overflow    (overflow),
    .div0        (div0),
    .o_dbg_state (dbg_state)
  );

  // ---- clock / cycle counter ----
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard ----
  logic [2*W+1:0] exp_q[$];
  int             cyc_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  logic [2*W+1:0] m_exp;
  int             m_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, expected no pending result", cyc);
      end else begin
        m_exp = exp_q.pop_front();
        m_cyc = cyc_q.pop_front();
        check("result{quot,rem,ovf,div0}", {14'd0, quot, rem, overflow, div0}, {14'd0, m_exp});
        check("done_latency", cyc, m_cyc);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // ---- driver ----
  task automatic issue(input logic s, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic ov,
                       input logic dz, input bit push, input bit b2b);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout at cycle %0d: got busy=1, expected busy=0", cyc);
    end
    if (b2b) check("b2b_done_cycle", {31'd0, done}, 32'd1);
    go       = 1'b1;
    sgn      = s;
    dividend = dvd;
    divisor  = dvs;
    if (push) begin
      exp_q.push_back({q, r, ov, dz});
      cyc_q.push_back(cyc + 1 + W + 2);
    end
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", {31'd0, busy}, 32'd1);
  endtask

  // ---- stimulus ----
  initial begin
    int t;
    rst = 1'b1; go = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {26'd0, busy, done, quot, rem, overflow, div0}, 32'd0);
    rst = 1'b0;

    // unsigned directed vectors, issued back to back
    issue(1'b0, 16'd46845,  8'd200,  8'd234,  8'd45,   1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 16'd51200,  8'd200,  8'hFF,   8'h00,   1'b1, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 16'd100,    8'd0,    8'hFF,   8'h00,   1'b1, 1'b1, 1'b1, 1'b1);
    issue(1'b0, 16'd1000,   8'd10,   8'd100,  8'd0,    1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 16'hFEFF,   8'hFF,   8'hFF,   8'hFE,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 16'd255,    8'd255,  8'd1,    8'd0,    1'b0, 1'b0, 1'b1, 1'b1);

    // sgn=1 vectors; without signed support the same operands divide unsigned
`ifdef IDIVN_SIGNED_EN
    issue(1'b1, 16'hFF9C,   8'h07,   8'hF2,   8'hFE,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h8000,   8'hFF,   8'hFF,   8'h00,   1'b1, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h0064,   8'hF9,   8'hF2,   8'h02,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'hFC00,   8'h08,   8'h80,   8'h00,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h0400,   8'h08,   8'hFF,   8'h00,   1'b1, 1'b0, 1'b1, 1'b1);
`else
    issue(1'b1, 16'hFF9C,   8'h07,   8'hFF,   8'h00,   1'b1, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h8000,   8'hFF,   8'h80,   8'h80,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h0064,   8'hF9,   8'h00,   8'h64,   1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'hFC00,   8'h08,   8'hFF,   8'h00,   1'b1, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 16'h0400,   8'h08,   8'h80,   8'h00,   1'b0, 1'b0, 1'b1, 1'b1);
`endif
    issue(1'b1, 16'd100,    8'd0,    8'hFF,   8'h00,   1'b1, 1'b1, 1'b1, 1'b1);

    // go pulsed mid-operation must not disturb it
    issue(1'b0, 16'd46845,  8'd200,  8'd234,  8'd45,   1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    go = 1'b1; sgn = 1'b0; dividend = 16'd100; divisor = 8'd3;
    @(negedge clk);
    go = 1'b0;

    // reset four cycles into an operation: abandoned, no done pulse
    issue(1'b0, 16'd1000,   8'd7,    8'd0,    8'd0,    1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset_outputs", {26'd0, busy, done, quot, rem, overflow, div0}, 32'd0);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("idle_after_abort", {31'd0, busy}, 32'd0);

    issue(1'b0, 16'd46845,  8'd200,  8'd234,  8'd45,   1'b0, 1'b0, 1'b1, 1'b0);

    // drain outstanding results
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
